demux1x2_buffered: RTL and testbench
====================================

DEMUX1X2_BUFFERED -- requirements
Module: demux1x2_buffered

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_data, input, WIDTH, word to route.
REQ-005 SHALL have port in_sel, input, 1, destination: 0 -> port 0, 1 -> port 1.
REQ-006 SHALL have port in_valid, input, 1, in_data/in_sel valid.
REQ-007 SHALL have port in_ready, output, 1, selected destination can accept.
REQ-008 SHALL have ports out0_data / out1_data, output, WIDTH, head word of each port buffer.
REQ-009 SHALL have ports out0_valid / out1_valid, output, 1, port buffer non-empty.
REQ-010 SHALL have ports out0_ready / out1_ready, input, 1, downstream accepts.
REQ-011 SHALL have ports cnt0 / cnt1, output, 16, accepted-word counters (only with DEMUX_STATS_EN).

Function
REQ-012 SHALL accept a word when in_valid and in_ready are both 1 at a rising edge (push).
REQ-013 SHALL push an accepted word into the buffer selected by in_sel only; other buffer unchanged.
REQ-014 SHALL give each port an independent 2-entry FIFO; order within a port preserved.
REQ-015 SHALL drive in_ready = 1 iff the buffer selected by the current in_sel holds fewer than 2 words (combinational on in_sel and count only; never on in_valid or outK_ready).
REQ-016 SHALL pop port K when outK_valid and outK_ready are both 1 at a rising edge.
REQ-017 SHALL have latency 1: word pushed at edge N appears on outK_data with outK_valid = 1 from edge N onward when the buffer was empty; no combinational input-to-output data path.
REQ-018 SHALL, on simultaneous push and pop of the same port with count 1, keep count 1 and present the new word after the edge.
REQ-019 SHALL not push into a full buffer even if that port pops in the same cycle (no full-buffer pass-through).
REQ-020 SHALL let ports pop independently and simultaneously; a stalled port SHALL not block pushes to the other port.
REQ-021 SHALL hold outK_data stable while outK_valid = 1 and outK_ready = 0.
REQ-022 SHALL ignore in_data/in_sel when in_valid = 0; outK_data is don't-care when outK_valid = 0.
REQ-023 SHALL wrap 1-bit read/write pointers of each FIFO modulo 2.

Reset
REQ-024 SHALL, while rst_n = 0, clear both FIFO counts and pointers: out0_valid = out1_valid = 0, outK_data = 0, cnt0 = cnt1 = 0.
REQ-025 SHALL drive in_ready = 1 during and right after reset (both buffers empty).
REQ-026 SHALL discard buffered words when reset asserts mid-operation; deassertion SHALL resume from empty.

Configuration
REQ-027 SHALL use macro DEMUX_STATS_EN to compile in statistics.
REQ-028 With DEMUX_STATS_EN defined, cntK SHALL increment by 1 on each push to port K, saturating at 16'hFFFF.
REQ-029 Without DEMUX_STATS_EN, ports cnt0/cnt1 and counter logic SHALL be absent; datapath behaviour identical.

Structure
REQ-030 SHALL take constants DEMUX_DEPTH = 2 and DEMUX_CNT_W = 16 from shared package/include demux_pkg.
REQ-031 SHALL implement each port buffer as one instance of sub-module demux_fifo2 (parameter WIDTH; push, pop, data, count, full, empty), instantiated twice.

Verification
REQ-032 Reset check: assert rst_n = 0 mid-stream with 2 words buffered in port 0 -> out0_valid = 0, cnt0 = 0, in_ready = 1 immediately.
REQ-033 Routing: push 8'hA5 sel 0, 8'h3C sel 1, all readies 1 -> out0 shows A5 and out1 shows 3C one edge after each push; other port valid stays 0.
REQ-034 Backpressure: out0_ready = 0, push 8'h01, 8'h02 sel 0 -> in_ready = 0 for sel 0, 1 for sel 1; push 8'h03 sel 1 accepted; release out0_ready -> 01 then 02 in order.
REQ-035 Full with pop: port 0 full, in_sel = 0, in_valid = 1, out0_ready = 1 -> no push that edge; count drops to 1, push accepted next edge.
REQ-036 Simultaneous push/pop: port 1 holds 8'h10, push 8'h20 sel 1 with out1_ready = 1 -> after edge out1_data = 20, count 1.
REQ-037 Stats (DEMUX_STATS_EN): preload cnt1 path with 65537 pushes sel 1 -> cnt1 = 16'hFFFF, cnt0 = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the buffered 1x2 demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_DEPTH   = 2;
    localparam int unsigned DEMUX_CNT_W   = 16;
    localparam int unsigned DEMUX_FCOUNT_W = $clog2(DEMUX_DEPTH + 1);

    // Saturating increment for the accepted-word statistics counters.
    function automatic logic [DEMUX_CNT_W-1:0] sat_inc(input logic [DEMUX_CNT_W-1:0] v);
        return (v == {DEMUX_CNT_W{1'b1}}) ? v : v + DEMUX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux1x2_buffered_if.sv
// Input word stream plus two buffered output streams of the 1x2 demultiplexer.
interface demux1x2_buffered_if #(parameter int unsigned WIDTH = 8) ();

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with 1-bit wrapping pointers; head word is read straight from storage.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic [DEMUX_FCOUNT_W-1:0] count,
    output logic                      full,
    output logic                      empty
);

    logic [WIDTH-1:0] mem [DEMUX_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full buffer never accepts, even when it pops in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEMUX_DEPTH); i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + DEMUX_FCOUNT_W'(1);
                2'b01:   count <= count - DEMUX_FCOUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == DEMUX_FCOUNT_W'(DEMUX_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/demux1x2_buffered.sv
// Routes each accepted word into one of two independent 2-entry port buffers.
// Optional accepted-word counters cnt0/cnt1 are compiled in with DEMUX_STATS_EN.
module demux1x2_buffered
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux1x2_buffered_if.slave     bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [DEMUX_CNT_W-1:0] cnt0,
    output logic [DEMUX_CNT_W-1:0] cnt1
`endif
);

    logic                      push0, push1;
    logic                      pop0, pop1;
    logic                      full0, full1;
    logic                      empty0, empty1;
    logic [DEMUX_FCOUNT_W-1:0] count0, count1;
    logic                      unused_counts;

    // Readiness depends only on the selected buffer's occupancy.
    assign bus.in_ready = bus.in_sel ? !full1 : !full0;

    assign push0 = bus.in_valid && bus.in_ready && !bus.in_sel;
    assign push1 = bus.in_valid && bus.in_ready &&  bus.in_sel;
    assign pop0  = bus.out0_valid && bus.out0_ready;
    assign pop1  = bus.out1_valid && bus.out1_ready;

    assign bus.out0_valid = !empty0;
    assign bus.out1_valid = !empty1;
    assign unused_counts  = ^{count0, count1};

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .din   (bus.in_data),
        .dout  (bus.out0_data),
        .count (count0),
        .full  (full0),
        .empty (empty0)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .din   (bus.in_data),
        .dout  (bus.out1_data),
        .count (count1),
        .full  (full1),
        .empty (empty1)
    );

`ifdef DEMUX_STATS_EN
    // Per-port accepted-word counters, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) cnt0 <= sat_inc(cnt0);
            if (push1) cnt1 <= sat_inc(cnt1);
        end
    end
`endif

endmodule

// File: tb/tb_demux1x2_buffered.sv
// Bench for demux1x2_buffered: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_demux1x2_buffered;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    demux1x2_buffered_if #(.WIDTH(W)) bus ();

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0, cnt1;
    demux1x2_buffered #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt0(cnt0), .cnt1(cnt1));
`else
    demux1x2_buffered #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Reference model: each port is a queue of at most two words.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           m_cnt0 = 0;
    int           m_cnt1 = 0;

    always @(posedge clk or negedge rst_n) begin
        int s0, s1;
        bit acc;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            s0  = q0.size();
            s1  = q1.size();
            acc = bus.in_valid && ((bus.in_sel ? s1 : s0) < 2);
            if (bus.out0_ready && s0 > 0) void'(q0.pop_front());
            if (bus.out1_ready && s1 > 0) void'(q1.pop_front());
            if (acc) begin
                if (bus.in_sel) begin
                    q1.push_back(bus.in_data);
                    if (m_cnt1 < 65535) m_cnt1++;
                end else begin
                    q0.push_back(bus.in_data);
                    if (m_cnt0 < 65535) m_cnt0++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_v0", 32'(bus.out0_valid), 0);
            chk("rst_v1", 32'(bus.out1_valid), 0);
            chk("rst_d0", 32'(bus.out0_data), 0);
            chk("rst_d1", 32'(bus.out1_data), 0);
            chk("rst_rdy", 32'(bus.in_ready), 1);
        end else begin
            chk("v0", 32'(bus.out0_valid), 32'(q0.size() != 0));
            chk("v1", 32'(bus.out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) chk("d0", 32'(bus.out0_data), 32'(q0[0]));
            if (q1.size() != 0) chk("d1", 32'(bus.out1_data), 32'(q1[0]));
            chk("rdy", 32'(bus.in_ready), 32'(((bus.in_sel ? q1.size() : q0.size()) < 2)));
        end
`ifdef DEMUX_STATS_EN
        chk("cnt0", 32'(cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input bit s, input logic [W-1:0] d, input bit r0, input bit r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle();
        settle();
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(0, 0, '0, 1, 1);
        #1;
        chk("por_rdy", 32'(bus.in_ready), 1);
        chk("por_v0", 32'(bus.out0_valid), 0);
        do_reset();

        // Routing: one word to each port.
        set_in(1, 0, 8'hA5, 1, 1);
        settle();
        chk("rt_d0", 32'(bus.out0_data), 32'h A5);
        chk("rt_v0", 32'(bus.out0_valid), 1);
        chk("rt_v1", 32'(bus.out1_valid), 0);
        set_in(1, 1, 8'h3C, 1, 1);
        settle();
        chk("rt_d1", 32'(bus.out1_data), 32'h3C);
        chk("rt_v1b", 32'(bus.out1_valid), 1);
        chk("rt_v0b", 32'(bus.out0_valid), 0);
        set_in(0, 0, '0, 1, 1);
        settle();

        // Backpressure on port 0 does not block port 1.
        set_in(1, 0, 8'h01, 0, 1);
        settle();
        set_in(1, 0, 8'h02, 0, 1);
        settle();
        chk("bp_rdy0", 32'(bus.in_ready), 0);
        bus.in_sel   = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("bp_rdy1", 32'(bus.in_ready), 1);
        set_in(1, 1, 8'h03, 0, 1);
        settle();
        chk("bp_d1", 32'(bus.out1_data), 32'h03);
        chk("bp_d0a", 32'(bus.out0_data), 32'h01);
        set_in(0, 0, '0, 1, 1);
        settle();
        chk("bp_d0b", 32'(bus.out0_data), 32'h02);
        chk("bp_v1", 32'(bus.out1_valid), 0);
        settle();
        chk("bp_v0", 32'(bus.out0_valid), 0);

        // Full buffer with pop: no push on that edge, push on the next.
        set_in(1, 0, 8'h11, 0, 1);
        settle();
        set_in(1, 0, 8'h22, 0, 1);
        settle();
        set_in(1, 0, 8'h33, 1, 1);
        #1;
        chk("fp_rdy_full", 32'(bus.in_ready), 0);
        settle();
        chk("fp_d0a", 32'(bus.out0_data), 32'h22);
        chk("fp_rdy", 32'(bus.in_ready), 1);
        settle();
        chk("fp_d0b", 32'(bus.out0_data), 32'h33);
        chk("fp_v0", 32'(bus.out0_valid), 1);
        set_in(0, 0, '0, 1, 1);
        settle();
        chk("fp_v0e", 32'(bus.out0_valid), 0);

        // Simultaneous push and pop on port 1, then hold while stalled.
        set_in(1, 1, 8'h10, 1, 0);
        settle();
        chk("sp_d1a", 32'(bus.out1_data), 32'h10);
        set_in(1, 1, 8'h20, 1, 1);
        settle();
        chk("sp_d1b", 32'(bus.out1_data), 32'h20);
        chk("sp_rdy", 32'(bus.in_ready), 1);
        set_in(0, 1, 8'hEE, 1, 0);
        settle();
        chk("sp_hold", 32'(bus.out1_data), 32'h20);
        set_in(0, 0, '0, 1, 1);
        settle();

        // Reset mid-stream with two words buffered in port 0.
        set_in(1, 0, 8'h44, 0, 1);
        settle();
        set_in(1, 0, 8'h55, 0, 1);
        settle();
        set_in(0, 0, '0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_v0", 32'(bus.out0_valid), 0);
        chk("mr_rdy", 32'(bus.in_ready), 1);
`ifdef DEMUX_STATS_EN
        chk("mr_cnt0", 32'(cnt0), 0);
`endif
        settle();
        rst_n = 1'b1;
        settle();
        chk("mr_v0b", 32'(bus.out0_valid), 0);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom),
                   1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                settle();
                rst_n = 1'b1;
            end else begin
                settle();
            end
        end

`ifdef DEMUX_STATS_EN
        // Saturation of the port 1 counter.
        set_in(0, 0, '0, 1, 1);
        do_reset();
        set_in(1, 1, 8'h77, 1, 1);
        for (int i = 0; i < 65537; i++) settle();
        set_in(0, 0, '0, 1, 1);
        settle();
        chk("sat_cnt1", 32'(cnt1), 32'h0000_FFFF);
        chk("sat_cnt0", 32'(cnt0), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
